// File: rtl/param_fifo_pkg.sv
// Shared constants for the memory/IO blocks: default entry width and address width.
// Imported by param_fifo and fifo_ram so every block agrees on the defaults.
package param_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

endpackage : param_fifo_pkg

// File: rtl/param_fifo_ram.sv
// fifo_ram: DEPTH x DATA_WIDTH storage with one synchronous write port and one
// asynchronous read port, so the FIFO head is visible combinationally (show-ahead).
module fifo_ram
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; stale contents are harmless because the
  // pointers and count decide what is valid, and this keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : fifo_ram

// File: rtl/param_fifo.sv
// param_fifo: single-clock show-ahead FIFO with registered status flags,
// almost-full/almost-empty thresholds, overflow/underflow pulses and a sync flush.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_do_rd;
  logic                  w_do_wr;
  logic [CW-1:0]         w_count_next;

  // A read needs stored data now; a write into empty never bypasses to the read.
  // Clear overrides both, so nothing is stored or popped during a flush.
  assign w_do_rd = read & ~r_empty & ~clear;
  assign w_do_wr = write & (~r_full | w_do_rd) & ~clear;

  // NOTE: default assignment first so every path drives the signal and no latch is inferred.
  always_comb begin
    w_count_next = r_count;
    if (clear) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + CW'(w_do_wr) - CW'(w_do_rd);
    end
  end

  // Flags are computed from the next count so they line up with count itself.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_full  <= (AF_LEVEL == 0);
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_do_wr) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
        if (w_do_rd) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      r_count        <= w_count_next;
      r_empty        <= (w_count_next == '0);
      r_full         <= (int'(w_count_next) == DEPTH);
      r_almost_full  <= (int'(w_count_next) >= AF_LEVEL);
      r_almost_empty <= (int'(w_count_next) <= AE_LEVEL);
      r_overflow     <= write & ~w_do_wr & ~clear;
      r_underflow    <= read & ~w_do_rd & ~clear;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_do_wr),
    .i_waddr(r_wr_ptr),
    .i_wdata(writedata),
    .i_raddr(r_rd_ptr),
    .o_rdata(readdata)
  );

  assign empty        = r_empty;
  assign full         = r_full;
  assign count        = r_count;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule : param_fifo
